// File: rtl/ddr4_cmd_sequencer.sv
// Closed-page DDR4 command sequencer: one request becomes ACT -> RD/WR -> PRE with
// programmable spacing, write-beat drive and read-beat capture. All pins are registered.
module ddr4_cmd_sequencer #(
  parameter int ADDRWIDTH = 17,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int COLWIDTH  = 10,
  parameter int CHIPS     = 16,
  parameter int DQWIDTH   = 64,
  parameter int BL        = 8,
  parameter int TINIT     = 5,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int CWL       = 0,
  parameter int TWR       = 4,
  parameter int TRP       = 15
) (
  input  logic                    ck_t,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [BGWIDTH-1:0]      req_bg,
  input  logic [BAWIDTH-1:0]      req_ba,
  input  logic [ADDRWIDTH-1:0]    req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic [BL*DQWIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic                    resp_write,
  output logic [BL*DQWIDTH-1:0]   resp_rdata,
  output logic                    cke,
  output logic                    cs_n,
  output logic                    act_n,
  output logic [ADDRWIDTH-1:0]    A,
  output logic [BGWIDTH-1:0]      bg,
  output logic [BAWIDTH-1:0]      ba,
  output logic                    odt,
  output logic                    parity,
  output logic [DQWIDTH-1:0]      dq_o,
  output logic                    dq_oe,
  input  logic [DQWIDTH-1:0]      dq_i,
  output logic [CHIPS-1:0]        dqs_t_o,
  output logic [CHIPS-1:0]        dqs_c_o
);

  localparam int CW = 16;
  localparam int DW = BL*DQWIDTH;

  // Cycle offsets are measured from the ACT cycle (cycle 0).
  localparam logic [CW-1:0] T_CAS    = CW'(TRCD);
  localparam logic [CW-1:0] W_FIRST  = CW'(TRCD + CWL);
  localparam logic [CW-1:0] W_LAST   = CW'(TRCD + CWL + BL - 1);
  localparam logic [CW-1:0] W_PRE    = CW'(TRCD + CWL + BL + TWR);
  localparam logic [CW-1:0] R_FIRST  = CW'(TRCD + TCL);
  localparam logic [CW-1:0] R_LAST   = CW'(TRCD + TCL + BL - 1);
  localparam logic [CW-1:0] R_PRE    = CW'(TRCD + TCL + BL);
  localparam logic [CW-1:0] INIT_END = CW'(TINIT);
  localparam logic [CW-1:0] RP_END   = CW'(TRP - 1);

  localparam logic [ADDRWIDTH-1:0] A_NOP = ADDRWIDTH'(17'h1C000);
  localparam logic [ADDRWIDTH-1:0] A_WR  = ADDRWIDTH'(17'h10000);
  localparam logic [ADDRWIDTH-1:0] A_RD  = ADDRWIDTH'(17'h14000);
  localparam logic [ADDRWIDTH-1:0] A_PRE = ADDRWIDTH'(17'h08000);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_ACT, S_RCD, S_CAS, S_WDATA, S_WRREC, S_RLAT, S_RDATA, S_PRE, S_RP
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;
    logic [ADDRWIDTH-1:0] row;
    logic [COLWIDTH-1:0]  col;
    logic [DW-1:0]        wdata;
  } req_t;

  typedef struct packed {
    logic                 cke;
    logic                 cs_n;
    logic                 act_n;
    logic [ADDRWIDTH-1:0] A;
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;
    logic                 odt;
    logic                 parity;
    logic [DQWIDTH-1:0]   dq_o;
    logic                 dq_oe;
    logic [CHIPS-1:0]     dqs_t;
    logic [CHIPS-1:0]     dqs_c;
    logic                 req_ready;
    logic                 resp_valid;
    logic                 resp_write;
  } pins_t;

  function automatic pins_t rst_pins();
    pins_t p;
    p       = '0;
    p.cke   = 1'b1;
    p.cs_n  = 1'b1;
    p.act_n = 1'b1;
    p.dqs_c = '1;
    return p;
  endfunction

  function automatic logic busy(input state_t s);
    return s inside {S_ACT, S_RCD, S_CAS, S_WDATA, S_WRREC, S_RLAT, S_RDATA};
  endfunction

  // Post-ACT phase is a pure function of the cycle offset and direction.
  function automatic state_t seq_state(input logic [CW-1:0] c, input logic wr);
    if (c < T_CAS)  return S_RCD;
    if (c == T_CAS) return S_CAS;
    if (wr) begin
      if (c <= W_LAST) return S_WDATA;
      if (c < W_PRE)   return S_WRREC;
    end else begin
      if (c < R_FIRST) return S_RLAT;
      if (c < R_PRE)   return S_RDATA;
    end
    return S_PRE;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  req_t            lat_q, lat_d;
  pins_t           pins_q, pins_d;
  logic [CW-1:0]   wbeat, rbeat;
  logic            wr_win, rd_cap;
  logic [DW-1:0]   rd_buf, rd_next;

  always_ff @(posedge ck_t) begin
    if (reset) begin
      state_q    <= S_INIT;
      cyc_q      <= '0;
      lat_q      <= '0;
      pins_q     <= rst_pins();
      rd_buf     <= '0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      lat_q   <= lat_d;
      pins_q  <= pins_d;
      if (rd_cap) begin
        rd_buf <= rd_next;
        if (cyc_q == R_LAST) resp_rdata <= rd_next;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    lat_d   = lat_q;
    unique case (state_q)
      S_INIT: if (cyc_q >= INIT_END) begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
      S_IDLE: begin
        cyc_d = '0;
        if (req_valid && req_ready) begin
          state_d = S_ACT;
          lat_d   = {req_write, req_bg, req_ba, req_row, req_col, req_wdata};
        end
      end
      S_PRE: begin
        state_d = S_RP;
        cyc_d   = '0;
      end
      S_RP: if (cyc_q >= RP_END) begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
      default: state_d = seq_state(cyc_d, lat_q.write);
    endcase
  end

  // Pins are computed from the next state so they appear registered in that state's cycle.
  always_comb begin
    pins_d            = rst_pins();
    pins_d.cs_n       = 1'b0;
    pins_d.A          = A_NOP;
    pins_d.resp_write = pins_q.resp_write;
    wr_win = busy(state_d) && lat_d.write && (cyc_d >= W_FIRST) && (cyc_d <= W_LAST);
    wbeat  = '0;
    unique case (state_d)
      S_INIT: begin
        pins_d.cs_n = 1'b1;
        pins_d.A    = '0;
      end
      S_IDLE: pins_d.req_ready = 1'b1;
      S_ACT: begin
        pins_d.act_n = 1'b0;
        pins_d.A     = lat_d.row;
      end
      S_CAS: pins_d.A = (lat_d.write ? A_WR : A_RD) | ADDRWIDTH'(lat_d.col);
      S_PRE: begin
        pins_d.A          = A_PRE;
        pins_d.resp_valid = 1'b1;
        pins_d.resp_write = lat_d.write;
      end
      default: ;
    endcase
    if (busy(state_d) || state_d == S_PRE) begin
      pins_d.bg = lat_d.bg;
      pins_d.ba = lat_d.ba;
    end
    if (wr_win) begin
      wbeat        = cyc_d - W_FIRST;
      pins_d.dq_oe = 1'b1;
      pins_d.odt   = 1'b1;
      pins_d.dq_o  = lat_d.wdata[int'(wbeat)*DQWIDTH +: DQWIDTH];
      pins_d.dqs_t = '1;
      pins_d.dqs_c = '0;
    end
    pins_d.parity = ~pins_d.cs_n & (^{pins_d.act_n, pins_d.bg, pins_d.ba, pins_d.A});
  end

  // Read beats land in rd_buf; the last beat also publishes the whole burst.
  assign rd_cap = busy(state_q) && !lat_q.write && (cyc_q >= R_FIRST) && (cyc_q <= R_LAST);

  always_comb begin
    rbeat   = rd_cap ? (cyc_q - R_FIRST) : '0;
    rd_next = rd_buf;
    rd_next[int'(rbeat)*DQWIDTH +: DQWIDTH] = dq_i;
  end

  assign cke        = pins_q.cke;
  assign cs_n       = pins_q.cs_n;
  assign act_n      = pins_q.act_n;
  assign A          = pins_q.A;
  assign bg         = pins_q.bg;
  assign ba         = pins_q.ba;
  assign odt        = pins_q.odt;
  assign parity     = pins_q.parity;
  assign dq_o       = pins_q.dq_o;
  assign dq_oe      = pins_q.dq_oe;
  assign dqs_t_o    = pins_q.dqs_t;
  assign dqs_c_o    = pins_q.dqs_c;
  assign req_ready  = pins_q.req_ready;
  assign resp_valid = pins_q.resp_valid;
  assign resp_write = pins_q.resp_write;

endmodule
